// File: rtl/wallace_mult_pkg.sv
// Shared widths and operand-unpacking helper for the shared-multiplier arbiter.
package wallace_mult_pkg;

    localparam int OP_W    = 4;
    localparam int PROD_W  = 8;
    localparam int MAX_REQ = 8;

    // Callers zero-extend their packed vector to MAX_REQ lanes before calling.
    function automatic logic [OP_W-1:0] get_operand(input logic [MAX_REQ*OP_W-1:0] vec,
                                                    input int unsigned idx);
        return vec[idx*OP_W +: OP_W];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             grant_valid
);

    int idx;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = ID_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wallace_multiplier.sv
// 4x4 unsigned multiplier: partial products reduced by two 3:2 carry-save layers, then one adder.
module wallace_multiplier
    import wallace_mult_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] m
);

    logic [PROD_W-1:0] pp0, pp1, pp2, pp3;
    logic [PROD_W-1:0] s1, c1, s2, c2;

    assign pp0 = PROD_W'(a & {OP_W{b[0]}});
    assign pp1 = PROD_W'(a & {OP_W{b[1]}}) << 1;
    assign pp2 = PROD_W'(a & {OP_W{b[2]}}) << 2;
    assign pp3 = PROD_W'(a & {OP_W{b[3]}}) << 3;

    // Dropping carries out of bit 7 is safe: the true product never exceeds 225.
    assign s1 = pp0 ^ pp1 ^ pp2;
    assign c1 = ((pp0 & pp1) | (pp0 & pp2) | (pp1 & pp2)) << 1;

    assign s2 = s1 ^ c1 ^ pp3;
    assign c2 = ((s1 & c1) | (s1 & pp3) | (c1 & pp3)) << 1;

    assign m = s2 + c2;

endmodule

// File: rtl/wallace_mult_arbiter.sv
// Round-robin sharing of one Wallace multiplier among N_REQ valid/ready clients,
// with an operand register before and a response register after the multiplier.
module wallace_mult_arbiter
    import wallace_mult_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*OP_W-1:0]   req_a,
    input  logic [N_REQ*OP_W-1:0]   req_b,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [PROD_W-1:0]       rsp_m,
    input  logic                    rsp_ready,
    output logic                    busy
);

    logic                     op_valid;
    logic [OP_W-1:0]          op_a, op_b;
    logic [ID_W-1:0]          op_id;
    logic [ID_W-1:0]          rr_ptr, ptr_next;
    logic                     adv1, adv2;
    logic [N_REQ-1:0]         grant;
    logic [ID_W-1:0]          grant_idx;
    logic                     grant_valid;
    logic                     handshake;
    logic [PROD_W-1:0]        prod;
    logic [MAX_REQ*OP_W-1:0]  a_ext, b_ext;

    assign a_ext = (MAX_REQ*OP_W)'(req_a);
    assign b_ext = (MAX_REQ*OP_W)'(req_b);

    assign adv2      = !rsp_valid || rsp_ready;
    assign adv1      = !op_valid || adv2;
    assign req_ready = adv1 ? grant : '0;
    assign handshake = adv1 && grant_valid;
    assign ptr_next  = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
    assign busy      = op_valid || rsp_valid;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    wallace_multiplier u_mult (
        .a (op_a),
        .b (op_b),
        .m (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            rr_ptr <= ptr_next;
        end
    end

    // S1 keeps stale operands when it empties; op_valid alone qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_id    <= '0;
        end else if (adv1) begin
            op_valid <= grant_valid;
            if (grant_valid) begin
                op_a  <= get_operand(a_ext, 32'(grant_idx));
                op_b  <= get_operand(b_ext, 32'(grant_idx));
                op_id <= grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_m     <= '0;
            rsp_id    <= '0;
        end else if (adv2) begin
            rsp_valid <= op_valid;
            rsp_m     <= prod;
            rsp_id    <= op_id;
        end
    end

endmodule

// File: tb/tb_wallace_mult_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_wallace_mult_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*4-1:0] req_a, req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [IW-1:0]  rsp_id;
    logic [7:0]     rsp_m;
    logic           rsp_ready;
    logic           busy;

    always #5 clk = ~clk;

    wallace_mult_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_m     (rsp_m),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    typedef struct {
        bit v;
        int id;
        int a;
        int b;
    } op_t;

    op_t          m_s1, m_s2;
    int           m_ptr;
    int           n_tests = 0;
    int           n_fail  = 0;
    int           obs_grant[$];
    int           obs_id[$];
    int           obs_m[$];
    logic [N-1:0] last_hs;
    int           g0, r0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1  = '{0, 0, 0, 0};
        m_s2  = '{0, 0, 0, 0};
        m_ptr = 0;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[4*i +: 4] = 4'(a);
        req_b[4*i +: 4] = 4'(b);
    endtask

    // One clock: check against the model at negedge, advance the model, return #1 after posedge.
    task automatic cycle();
        int           win;
        bit           adv1, adv2;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        adv2 = !m_s2.v || rsp_ready;
        adv1 = !m_s1.v || adv2;
        win  = -1;
        for (int k = 0; k < N; k++)
            if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        exp_rdy = '0;
        if (adv1 && win >= 0) exp_rdy[win] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(rsp_valid), 32'(m_s2.v));
        check("busy", 32'(busy), 32'(m_s1.v || m_s2.v));
        if (m_s2.v) begin
            check("rsp_id", 32'(rsp_id), 32'(m_s2.id));
            check("rsp_m", 32'(rsp_m), 32'(m_s2.a * m_s2.b));
        end
        if (rsp_valid && rsp_ready) begin
            obs_id.push_back(int'(rsp_id));
            obs_m.push_back(int'(rsp_m));
        end
        last_hs = req_ready & req_valid;
        for (int i = 0; i < N; i++)
            if (last_hs[i]) obs_grant.push_back(i);
        if (adv2) m_s2 = m_s1;
        if (adv1) begin
            if (win >= 0) begin
                m_s1  = '{1, win, int'(req_a[4*win +: 4]), int'(req_b[4*win +: 4])};
                m_ptr = (win + 1) % N;
            end else begin
                m_s1.v = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        req_valid = '0;
        rst_n     = 1'b0;
        #2;
        check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_rsp_m"}, 32'(rsp_m), 32'h0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'h0);
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        model_reset();
        #1;
        do_reset("por");

        // Single request from requester 2
        rsp_ready = 1'b1;
        set_op(2, 5, 6);
        req_valid = 4'b0100;
        g0 = obs_grant.size();
        r0 = obs_m.size();
        cycle();
        req_valid = '0;
        cycle();
        cycle();
        check("single_grant_cnt", 32'(obs_grant.size() - g0), 32'd1);
        check("single_grant", 32'(obs_grant[g0]), 32'd2);
        check("single_rsp_cnt", 32'(obs_m.size() - r0), 32'd1);
        check("single_m", 32'(obs_m[r0]), 32'h1E);
        check("single_id", 32'(obs_id[r0]), 32'd2);

        // Contention: all four valid, each drops after its grant
        do_reset("pre_cont");
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, i + 1, 3);
        req_valid = 4'b1111;
        g0 = obs_grant.size();
        r0 = obs_m.size();
        for (int k = 0; k < N + 2; k++) begin
            cycle();
            req_valid = req_valid & ~last_hs;
        end
        for (int k = 0; k < N; k++) begin
            check("cont_grant", 32'(obs_grant[g0 + k]), 32'(k));
            check("cont_m", 32'(obs_m[r0 + k]), 32'(3 * (k + 1)));
        end

        // Backpressure: two accepts, then the full pipeline stalls the third requester
        rsp_ready = 1'b0;
        set_op(0, 1, 2);
        set_op(1, 3, 4);
        set_op(2, 5, 5);
        req_valid = 4'b0111;
        r0 = obs_m.size();
        cycle();
        req_valid = req_valid & ~last_hs;
        cycle();
        req_valid = req_valid & ~last_hs;
        for (int k = 0; k < 3; k++) begin
            cycle();
            req_valid = req_valid & ~last_hs;
            check("bp_ready", 32'(req_ready), 32'h0);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_m_frozen", 32'(rsp_m), 32'h02);
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            req_valid = req_valid & ~last_hs;
        end
        check("bp_rsp_cnt", 32'(obs_m.size() - r0), 32'd3);
        check("bp_m0", 32'(obs_m[r0]), 32'h02);
        check("bp_m1", 32'(obs_m[r0 + 1]), 32'h0C);
        check("bp_m2", 32'(obs_m[r0 + 2]), 32'h19);
        check("bp_id1", 32'(obs_id[r0 + 1]), 32'd1);

        // Corner operand values, back-to-back from requester 1
        begin
            int ca[4] = '{15, 0, 7, 2};
            int cb[4] = '{15, 9, 8, 4};
            int cm[4] = '{'hE1, 'h00, 'h38, 'h08};
            r0 = obs_m.size();
            for (int k = 0; k < 4; k++) begin
                set_op(1, ca[k], cb[k]);
                req_valid = 4'b0010;
                cycle();
            end
            req_valid = '0;
            cycle();
            cycle();
            for (int k = 0; k < 4; k++)
                check("corner_m", 32'(obs_m[r0 + k]), 32'(cm[k]));
        end

        // Reset one cycle after a handshake discards the in-flight op
        set_op(3, 9, 9);
        req_valid = 4'b1000;
        cycle();
        req_valid = '0;
        cycle();
        do_reset("mid");
        r0 = obs_m.size();
        for (int k = 0; k < 3; k++) cycle();
        check("mid_no_rsp", 32'(obs_m.size() - r0), 32'd0);
        set_op(1, 2, 3);
        req_valid = 4'b1010;
        g0 = obs_grant.size();
        cycle();
        check("mid_next_grant", 32'(obs_grant[g0]), 32'd1);
        req_valid = '0;
        cycle();
        cycle();

        // Pointer wrap: 2 moves rr_ptr to 3, then 3 and 0 compete, then 1 and 2
        do_reset("pre_wrap");
        req_valid = 4'b0100;
        g0 = obs_grant.size();
        cycle();
        req_valid = 4'b1001;
        cycle();
        req_valid = req_valid & ~last_hs;
        cycle();
        req_valid = 4'b0110;
        cycle();
        req_valid = '0;
        cycle();
        cycle();
        check("wrap_g0", 32'(obs_grant[g0]), 32'd2);
        check("wrap_g1", 32'(obs_grant[g0 + 1]), 32'd3);
        check("wrap_g2", 32'(obs_grant[g0 + 2]), 32'd0);
        check("wrap_g3", 32'(obs_grant[g0 + 3]), 32'd1);

        // Randomized traffic with random backpressure; requesters hold until accepted
        g0 = obs_grant.size();
        r0 = obs_m.size();
        for (int c = 0; c < 400; c++) begin
            cycle();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_hs[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    set_op(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        check("rand_no_loss", 32'(obs_m.size() - r0), 32'(obs_grant.size() - g0));
        check("rand_idle", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wallace_mult_arbiter.md
# wallace_mult_arbiter

Shares one combinational `wallace_multiplier` (4×4 unsigned → 8-bit) among N_REQ requesters.
- Grant is round-robin; requests use a valid/ready handshake.
- Operands are registered before the multiplier and products are registered after it.
- Each product is returned on a single response channel, tagged with the requester ID.
- Sits between the multiplier datapath and the client blocks that need multiplies.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(N_REQ), width of requester ID

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_a  in  N_REQ*4  packed multiplicands; requester i uses bits [4i+3:4i]
- req_b  in  N_REQ*4  packed multipliers, same packing
- req_ready  out  N_REQ  per-requester accept, at most one bit set
- rsp_valid  out  1  product valid
- rsp_id  out  ID_W  requester that issued the product
- rsp_m  out  8  unsigned product
- rsp_ready  in  1  downstream accepts product
- busy  out  1  high when any pipeline stage holds an operation

## Operation
Datapath is a two-stage pipeline.
- **S1 (operand register):** op_valid, op_a, op_b, op_id.
- **Multiplier input:** `wallace_multiplier` is driven from op_a/op_b.
- **S2 (response register):** rsp_valid, rsp_m, rsp_id.

Advance rules:
- adv2 = !rsp_valid | rsp_ready.
- adv1 = !op_valid | adv2.

Arbitration:
- The rr_ptr (ID_W bits) starts search at rr_ptr, ascending with wrap; the first set req_valid wins.
- req_ready[g] = adv1 & grant[g]; all other bits are 0.
- A handshake on requester g loads S1 with {1, a_g, b_g, g}.
- On handshake, rr_ptr ← (g+1) mod N_REQ. Without a handshake rr_ptr holds.
- If adv1 is high and no req_valid is set, S1 loads op_valid=0.

Response stage:
- When adv2 is high, S2 ← {op_valid, m, op_id}.
- While rsp_valid=1 and rsp_ready=0, rsp_m and rsp_id hold stable.
- busy = op_valid | rsp_valid.

Arithmetic is unsigned and the full 8-bit product is returned; no truncation (15×15 = 225 = 8'hE1).

Requester rules:
- A requester must hold req_valid, req_a and req_b stable until it sees req_ready.
- Dropping valid before ready is a protocol violation; behaviour is not specified.

## Timing
- **Reset values:** rst_n low clears op_valid, op_a, op_b, op_id, rsp_valid, rsp_m, rsp_id and rr_ptr to 0 immediately. As a result req_ready=0 and busy=0.
- **Reset mid-operation:** all in-flight operations are discarded and no response is produced.
- **Latency:** a handshake at edge k gives rsp_valid=1 after edge k+1 when rsp_ready is held high. That is a two-cycle latency.
- **Throughput:** one accepted request per cycle when rsp_ready=1.
- **Full pipeline:** with S1 and S2 both valid and rsp_ready=0, req_ready is all zero and rr_ptr is frozen.
- **Simultaneous events:**
  - With rsp_ready=1 on a full pipeline, S2 takes S1 and S1 takes a new grant in the same edge.
  - No bubble is inserted.
- **Fairness:** with all N_REQ requesters continuously valid, grants cycle 0,1,…,N_REQ-1,0. No requester waits more than N_REQ-1 handshakes.
- **Combinational paths:** req_ready depends combinationally on req_valid and rsp_ready. No output depends combinationally on req_a or req_b.

## Structure
- **Package wallace_mult_pkg:** OP_W=4, PROD_W=8, and the packing helper function for extracting requester i's operand.
- **Sub-module rr_arbiter:** N_REQ request vector plus pointer in, one-hot grant and encoded grant index out, purely combinational.
- **Pointer register:** rr_ptr lives in the top level.
- **Multiplier:** one `wallace_multiplier` instance with ports a, b, m.

## Test plan
- **Single request:** reset, then requester 2 sends a=4'h5, b=4'h6 with rsp_ready=1. Expect req_ready[2] in the same cycle, then rsp_valid two edges later with rsp_m=8'h1E, rsp_id=2.
- **Contention:** all four requesters valid with a=i+1, b=4'h3. Expect grants in order 0,1,2,3 and products 03,06,09,0C back-to-back, one per cycle.
- **Backpressure:** hold rsp_ready=0 after two accepts.
  - Expect rsp_m frozen, then req_ready all 0 from the third cycle, busy=1.
  - Release rsp_ready: both results drain in order with no loss or duplication.
- **Corner values:** 4'hF×4'hF → 8'hE1; 4'h0×4'h9 → 8'h00; 4'h7×4'h8 → 8'h38; 4'h2×4'h4 → 8'h08.
- **Reset mid-flight:** assert rst_n low one cycle after a handshake. Expect rsp_valid=0, busy=0, and no response after release. The next grant goes to the lowest valid ID, since rr_ptr=0.
- **Pointer wrap:** requesters 3 and 0 valid, rr_ptr=3. Expect grant 3 then 0, with rr_ptr ending at 1.
